// File: rtl/div_pkg.sv
// Shared types for the multicycle divider: FSM state encoding and counter sizing.
package div_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      CALC = 2'd1,
      DONE = 2'd2
   } state_e;

   localparam int DIV_N_DEFAULT = 4;

   // Iteration counter must hold values 0..N.
   function automatic int cnt_width(input int n);
      return $clog2(n + 1);
   endfunction

endpackage

// File: rtl/div_step.sv
// One restoring shift-subtract iteration, purely combinational (zero latency).
// Never stalls; the caller decides when to register the result.
module div_step
   import div_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic [N:0]   r_i,
   input  logic [N-1:0] q_i,
   input  logic [N-1:0] divisor_i,
   output logic [N:0]   r_o,
   output logic [N-1:0] q_o
);

   logic [N:0] r_shift;
   logic [N:0] dvs_ext;
   logic       take;
   // The partial remainder is always below the divisor, so its top bit is shifted out unused.
   logic       unused_r_msb;

   assign unused_r_msb = r_i[N];

   always_comb begin
      r_shift = {r_i[N-1:0], q_i[N-1]};
      dvs_ext = {1'b0, divisor_i};
      take    = (r_shift >= dvs_ext);
      r_o     = take ? (r_shift - dvs_ext) : r_shift;
      q_o     = {q_i[N-2:0], take};
   end

endmodule

// File: rtl/multicycle_divider.sv
// Sequential unsigned restoring divider, N cycles from accepted start to done (1 for a zero divisor
// when DIVIDER_DBZ_ERROR_EN is defined); start is ignored while busy, results held until next start.
module multicycle_divider
   import div_pkg::*;
#(
   parameter int N = DIV_N_DEFAULT
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [N-1:0] dividend,
   input  logic [N-1:0] divisor,
   input  logic         start,
   output logic [N-1:0] quotient,
   output logic [N-1:0] remainder,
   output logic         error,
   output logic         done
);

   localparam int CW = cnt_width(N);

   state_e       state_q, state_d;
   logic [CW-1:0] cnt_q;
   logic [N:0]   r_q, r_step;
   logic [N-1:0] q_q, q_step;
   logic [N-1:0] dvs_q;
   logic [N-1:0] quot_q, rem_q;
   logic         done_q;

   logic         accept;
   logic         step_en;
   logic         finish;
   logic         fast_dbz;

`ifdef DIVIDER_DBZ_ERROR_EN
   logic dbz_q;
   logic error_q;

   // A zero divisor finishes on the first CALC edge instead of iterating.
   assign fast_dbz = dbz_q;
   assign error    = error_q;
`else
   assign fast_dbz = 1'b0;
   assign error    = 1'b0;
`endif

   div_step #(.N(N)) u_step (
      .r_i       (r_q),
      .q_i       (q_q),
      .divisor_i (dvs_q),
      .r_o       (r_step),
      .q_o       (q_step)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start)  state_d = CALC;
         CALC:    if (finish) state_d = DONE;
         DONE:    if (start)  state_d = CALC;
         default: state_d = IDLE;
      endcase
   end

   always_comb begin
      accept  = 1'b0;
      step_en = 1'b0;
      finish  = 1'b0;
      case (state_q)
         IDLE, DONE: accept = start;
         CALC: begin
            step_en = 1'b1;
            finish  = fast_dbz || (cnt_q == CW'(N - 1));
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         cnt_q  <= '0;
         r_q    <= '0;
         q_q    <= '0;
         dvs_q  <= '0;
         quot_q <= '0;
         rem_q  <= '0;
         done_q <= 1'b0;
`ifdef DIVIDER_DBZ_ERROR_EN
         dbz_q   <= 1'b0;
         error_q <= 1'b0;
`endif
      end else if (accept) begin
         cnt_q  <= '0;
         r_q    <= '0;
         q_q    <= dividend;
         dvs_q  <= divisor;
         done_q <= 1'b0;
`ifdef DIVIDER_DBZ_ERROR_EN
         dbz_q   <= (divisor == '0);
         error_q <= 1'b0;
`endif
      end else if (step_en) begin
         r_q   <= r_step;
         q_q   <= q_step;
         cnt_q <= cnt_q + CW'(1);
         if (finish) begin
            done_q <= 1'b1;
            if (fast_dbz) begin
               // q_q still holds the untouched dividend here.
               quot_q <= '1;
               rem_q  <= q_q;
            end else begin
               quot_q <= q_step;
               rem_q  <= r_step[N-1:0];
            end
`ifdef DIVIDER_DBZ_ERROR_EN
            error_q <= dbz_q;
`endif
         end
      end
   end

   assign quotient  = quot_q;
   assign remainder = rem_q;
   assign done      = done_q;

endmodule

// File: tb/tb_multicycle_divider.sv
// Scoreboard bench for multicycle_divider: stimulus pushes reference results, a monitor checks each done.
module tb_multicycle_divider;

   localparam int N = 4;

   typedef struct {
      logic [N-1:0] q;
      logic [N-1:0] r;
      logic         e;
      int           cyc;
   } exp_t;

   logic         clk = 1'b0;
   logic         reset = 1'b1;
   logic [N-1:0] dividend = '0;
   logic [N-1:0] divisor = '0;
   logic         start = 1'b0;
   logic [N-1:0] quotient;
   logic [N-1:0] remainder;
   logic         error;
   logic         done;

   exp_t sb_q[$];
   int   cyc = 0;
   int   n_chk = 0;
   int   n_fail = 0;
   bit   in_reset = 1'b1;
   logic done_prev = 1'b0;
   logic [N-1:0] prev_q = '0;
   logic [N-1:0] prev_r = '0;

   multicycle_divider #(.N(N)) dut (
      .clk       (clk),
      .reset     (reset),
      .dividend  (dividend),
      .divisor   (divisor),
      .start     (start),
      .quotient  (quotient),
      .remainder (remainder),
      .error     (error),
      .done      (done)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // Reference: plain integer division; a zero divisor yields all-ones and the dividend.
   function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b, input int acc_cyc);
      exp_t e;
      if (b == '0) begin
         e.q = '1;
         e.r = a;
      end else begin
         e.q = a / b;
         e.r = a % b;
      end
`ifdef DIVIDER_DBZ_ERROR_EN
      e.e   = (b == '0);
      e.cyc = acc_cyc + ((b == '0) ? 1 : N);
`else
      e.e   = 1'b0;
      e.cyc = acc_cyc + N;
`endif
      return e;
   endfunction

   task automatic tick();
      @(negedge clk);
      #1;
   endtask

   task automatic issue(input logic [N-1:0] a, input logic [N-1:0] b);
      start    = 1'b1;
      dividend = a;
      divisor  = b;
      tick();
      start    = 1'b0;
      dividend = $urandom_range(0, (1 << N) - 1);
      divisor  = $urandom_range(0, (1 << N) - 1);
      chk("done_clears_on_accept", done, 1'b0);
      sb_q.push_back(model(a, b, cyc));
   endtask

   task automatic wait_idle();
      int budget = 3 * N + 8;
      while (sb_q.size() != 0 && budget > 0) begin
         tick();
         budget--;
      end
      if (sb_q.size() != 0) begin
         chk("completion_timeout", sb_q.size(), 0);
         sb_q.delete();
      end
   endtask

   always @(negedge clk) begin
      if (!in_reset) begin
         if (done && !done_prev) begin
            if (sb_q.size() == 0) begin
               chk("unexpected_done", done, 1'b0);
            end else begin
               exp_t e;
               e = sb_q.pop_front();
               chk("quotient", quotient, e.q);
               chk("remainder", remainder, e.r);
               chk("error", error, e.e);
               chk("latency", cyc, e.cyc);
            end
         end else if (!done) begin
            chk("quotient_stable", quotient, prev_q);
            chk("remainder_stable", remainder, prev_r);
         end
      end
      done_prev = done;
      prev_q    = quotient;
      prev_r    = remainder;
   end

   initial begin
      tick();
      tick();
      reset = 1'b0;
      chk("reset_quotient", quotient, 0);
      chk("reset_remainder", remainder, 0);
      chk("reset_error", error, 0);
      chk("reset_done", done, 0);
      tick();
      in_reset = 1'b0;

      issue(4'd13, 4'd3); wait_idle();
      issue(4'd8, 4'd2);  wait_idle();
      issue(4'd7, 4'd0);  wait_idle();
      issue(4'd15, 4'd1); wait_idle();
      issue(4'd3, 4'd7);  wait_idle();

      // A start pulse in CALC must not disturb the running operation.
      issue(4'd13, 4'd3);
      start = 1'b1; dividend = 4'd5; divisor = 4'd1;
      tick();
      start = 1'b0;
      wait_idle();

      // Reset two cycles into an operation aborts it.
      issue(4'd13, 4'd3);
      tick();
      in_reset = 1'b1;
      reset    = 1'b1;
      start    = 1'b1;
      tick();
      reset = 1'b0;
      start = 1'b0;
      sb_q.delete();
      chk("abort_quotient", quotient, 0);
      chk("abort_remainder", remainder, 0);
      chk("abort_error", error, 0);
      chk("abort_done", done, 0);
      for (int i = 0; i < 2 * N; i++) begin
         tick();
         chk("abort_done_low", done, 0);
      end
      in_reset = 1'b0;

      issue(4'd9, 4'd4); wait_idle();

      for (int i = 0; i < 40; i++) begin
         issue(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
         wait_idle();
         if ($urandom_range(0, 1) == 1) tick();
      end

      tick();
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/multicycle_divider.md
Name: multicycle_divider

Overview:
- Sequential unsigned integer divider: restoring (shift-subtract) algorithm, one quotient bit per clock.
- Computes quotient and remainder of an N-bit dividend by an N-bit divisor.
- Start/done handshake; flags divide-by-zero.
- Used as a small arithmetic co-unit wherever a single-cycle divider is too costly.

Parameters:
- N, 4, operand/result width in bits (N >= 2).

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- dividend  input  N  unsigned dividend, sampled on the accepted start edge.
- divisor  input  N  unsigned divisor, sampled on the accepted start edge.
- start  input  1  request; accepted on a rising edge when not busy.
- quotient  output  N  registered quotient of the last completed operation.
- remainder  output  N  registered remainder of the last completed operation.
- error  output  1  divide-by-zero flag for the last operation.
- done  output  1  result valid; level, held until the next accepted start.

Behaviour:
- Clock and reset: one clock (clk). Reset is synchronous and active-high (reset).
- Reset values: quotient=0, remainder=0, error=0, done=0, state=IDLE; internal registers cleared.
- States: IDLE, CALC, DONE.
- Accepting start: a start sampled high in IDLE or DONE at edge k is accepted.
  - dividend and divisor are latched.
  - Partial remainder R (N+1 bits) = 0; quotient shift register Q = dividend; iteration counter = 0.
  - done and error clear; state -> CALC.
- CALC, one iteration per edge:
  - R' = {R[N-1:0], Q[N-1]}; Q shifts left.
  - If R' >= {0,divisor}: R = R' - divisor, Q[0] = 1. Else R = R', Q[0] = 0.
  - Counter increments.
- Completion: on the edge performing iteration N (edge k+N):
  - quotient = Q, remainder = R[N-1:0], done = 1; state -> DONE.
  - Latency is N cycles from the start edge to done high.
- DONE: outputs and done held until the next accepted start or reset.
- start while in CALC is ignored; operands are not re-sampled.
- start held high continuously restarts a new operation each time DONE is reached.
- Input changes outside the accepting edge have no effect.
- Divide by zero (divisor == 0 at accept):
  - Results: quotient = all ones, remainder = dividend.
  - These values fall out of the restoring algorithm naturally; the macro below only changes the error flag and the latency.
- reset during CALC aborts the operation: all outputs return to reset values, state -> IDLE.
- reset has priority over start on the same edge.
- quotient and remainder change only at completion or reset, never mid-calculation.
- Arithmetic is unsigned; subtraction uses N+1 bits so no overflow is possible.

Optional Feature:
- Macro: DIVIDER_DBZ_ERROR_EN.
- Defined:
  - A zero divisor at accept skips CALC; at edge k+1: done=1, error=1, quotient = all ones, remainder = dividend, state DONE.
  - error stays high until the next accepted start.
- Not defined:
  - error is tied to 0.
  - A zero divisor runs the full N iterations and completes with quotient = all ones, remainder = dividend at edge k+N.

Decomposition:
- Package div_pkg: state enum typedef (IDLE, CALC, DONE); localparam for counter width, $clog2(N+1).
- One natural sub-module, div_step: combinational single restoring iteration.
  - Inputs: R, Q, divisor.
  - Outputs: next R, next Q.
- Top holds the FSM, counter and output registers.

Test Plan:
- Reset, then start with 13/3 (N=4) -> done high exactly 4 cycles after the start edge; quotient=4, remainder=1, error=0.
- 8/2 -> quotient=4, remainder=0, error=0; done clears on the accepting edge and reasserts after 4 cycles.
- 7/0 with DIVIDER_DBZ_ERROR_EN -> done and error high at the next edge; quotient=15, remainder=7. Without the macro: error=0, same results after 4 cycles.
- 15/1 and 3/7 -> quotient=15, remainder=0; then quotient=0, remainder=3.
- Pulse start again mid-CALC with different operands -> ignored; original result delivered on schedule.
- Assert reset two cycles into a 13/3 operation -> all outputs 0, done stays low; a fresh 9/4 afterwards gives quotient=2, remainder=1.
